// File: rtl/pipeline_stage_buf.sv
// rtl/pipeline_stage_buf.sv - elastic valid-tagged pipeline register chain with stall, flush and bubble collapse
module pipeline_stage_buf #(
  parameter int DW    = 32,
  parameter int DEPTH = 2,
  parameter int CNTW  = $clog2(DEPTH+1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [DW-1:0]   in_data_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [DW-1:0]   out_data_o,
  output logic [CNTW-1:0] count_o
);

  // Stage 0 faces the upstream producer, stage DEPTH-1 drives the output.
  logic [DEPTH-1:0]         v_q, v_d;
  logic [DEPTH-1:0][DW-1:0] d_q, d_d;
  logic [DEPTH-1:0]         en;
  logic                     hold;

  // A stall or flush freezes both handshakes for the cycle.
  assign hold = stall_i | flush_i;

  // Advance enables ripple from the output back to the input; a running
  // scalar avoids a self-referencing vector so empty stages absorb their
  // predecessor even while the output is blocked.
  always_comb begin
    logic chain;
    en    = '0;
    chain = out_ready_i;
    for (int k = DEPTH-1; k >= 0; k--) begin
      chain = ~v_q[k] | chain;
      en[k] = chain;
    end
  end

  assign in_ready_o  = en[0] & ~hold;
  assign out_valid_o = v_q[DEPTH-1] & ~hold;
  assign out_data_o  = d_q[DEPTH-1];

  // Next-state: flush clears valids only, stall holds everything, otherwise
  // every enabled stage takes its predecessor; payload loads only with a valid.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush_i) begin
      v_d = '0;
    end else if (!stall_i) begin
      if (en[0]) begin
        v_d[0] = in_valid_i;
        if (in_valid_i) begin
          d_d[0] = in_data_i;
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (en[k]) begin
          v_d[k] = v_q[k-1];
          if (v_q[k-1]) begin
            d_d[k] = d_q[k-1];
          end
        end
      end
    end
  end

  // Stage registers; reset discards every in-flight payload and zeroes data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q <= '0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  // Occupancy is a popcount of the valid registers.
  always_comb begin
    count_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count_o = count_o + CNTW'(v_q[k]);
    end
  end

endmodule

// File: tb/tb_pipeline_stage_buf.sv
// tb/tb_pipeline_stage_buf.sv - directed self-checking bench for pipeline_stage_buf
module tb_pipeline_stage_buf;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // DEPTH=2 instance
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_count;
  // DEPTH=3 instance
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_stall, b_flush;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_count;
  // DEPTH=1 instance
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [31:0] c_in_data, c_out_data;
  logic [0:0]  c_count;
  logic        zero = 1'b0;

  pipeline_stage_buf #(.DW(32), .DEPTH(2)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .in_data_i(a_in_data), .stall_i(zero), .flush_i(zero), .out_valid_o(a_out_valid),
    .out_ready_i(a_out_ready), .out_data_o(a_out_data), .count_o(a_count));

  pipeline_stage_buf #(.DW(32), .DEPTH(3)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .in_data_i(b_in_data), .stall_i(b_stall), .flush_i(b_flush), .out_valid_o(b_out_valid),
    .out_ready_i(b_out_ready), .out_data_o(b_out_data), .count_o(b_count));

  pipeline_stage_buf #(.DW(32), .DEPTH(1)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(c_in_valid), .in_ready_o(c_in_ready),
    .in_data_i(c_in_data), .stall_i(zero), .flush_i(zero), .out_valid_o(c_out_valid),
    .out_ready_i(c_out_ready), .out_data_o(c_out_data), .count_o(c_count));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_cyc;
    int n_out;
    logic [31:0] exp_next;

    rst_n = 1'b0;
    a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = 0; b_out_ready = 0; b_stall = 0; b_flush = 0;
    c_in_valid = 0; c_in_data = 0; c_out_ready = 0;
    #2;
    check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    check("rst_b_count",     32'(b_count),     32'd0);
    check("rst_b_in_ready",  32'(b_in_ready),  32'd1);
    check("rst_c_in_ready",  32'(c_in_ready),  32'd1);
    #10;
    rst_n = 1'b1;
    tick();

    // Reset mid-stream, DEPTH=2 holding two entries with output blocked
    a_in_valid = 1; a_in_data = 32'hAA; tick();
    a_in_data = 32'hBB; tick();
    a_in_valid = 0; #1;
    check("a_full_count",     32'(a_count),     32'd2);
    check("a_full_in_ready",  32'(a_in_ready),  32'd0);
    check("a_full_out_valid", 32'(a_out_valid), 32'd1);
    check("a_full_out_data",  a_out_data,       32'hAA);
    rst_n = 1'b0; #1;
    check("a_rst_out_valid", 32'(a_out_valid), 32'd0);
    check("a_rst_out_data",  a_out_data,       32'd0);
    check("a_rst_count",     32'(a_count),     32'd0);
    check("a_rst_in_ready",  32'(a_in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Streaming DEPTH=3: 0x1..0x10 on consecutive cycles, output always ready
    b_out_ready = 1;
    first_cyc = -1; n_out = 0; exp_next = 32'd1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      b_in_valid = (cyc < 16);
      b_in_data  = 32'(cyc + 1);
      #1;
      if (cyc < 16) check("stream_in_ready", 32'(b_in_ready), 32'd1);
      if (cyc >= 3 && cyc < 19) check("stream_out_valid", 32'(b_out_valid), 32'd1);
      if (b_out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        check("stream_out_data", b_out_data, exp_next);
        exp_next++;
        n_out++;
      end
      tick();
    end
    check("stream_first_cycle", 32'(first_cyc), 32'd3);
    check("stream_total",       32'(n_out),     32'd16);

    // Back-pressure with bubble collapse: A, two idle cycles, then B and C
    b_out_ready = 0;
    b_in_valid = 1; b_in_data = 32'hA; tick();
    b_in_valid = 0; tick();
    tick();
    b_in_valid = 1; b_in_data = 32'hB; tick();
    b_in_data = 32'hC; tick();
    b_in_data = 32'hD; #1;
    check("bp_count",     32'(b_count),     32'd3);
    check("bp_in_ready",  32'(b_in_ready),  32'd0);
    check("bp_out_data",  b_out_data,       32'hA);
    tick();
    b_in_valid = 0; b_out_ready = 1; #1;
    check("bp_hold_count", 32'(b_count), 32'd3);
    check("bp_rel0_valid", 32'(b_out_valid), 32'd1);
    check("bp_rel0_data",  b_out_data, 32'hA);
    tick();
    check("bp_rel1_valid", 32'(b_out_valid), 32'd1);
    check("bp_rel1_data",  b_out_data, 32'hB);
    tick();
    check("bp_rel2_valid", 32'(b_out_valid), 32'd1);
    check("bp_rel2_data",  b_out_data, 32'hC);
    tick();
    check("bp_empty_valid", 32'(b_out_valid), 32'd0);
    check("bp_empty_count", 32'(b_count), 32'd0);

    // Stall with two entries held, both sides offering a transfer
    b_out_ready = 0;
    b_in_valid = 1; b_in_data = 32'h11; tick();
    b_in_valid = 0; tick();
    tick();
    b_in_valid = 1; b_in_data = 32'h22; tick();
    b_in_valid = 0; tick();
    check("stall_pre_count", 32'(b_count), 32'd2);
    b_stall = 1; b_in_valid = 1; b_in_data = 32'h33; b_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_in_ready",  32'(b_in_ready),  32'd0);
      check("stall_out_valid", 32'(b_out_valid), 32'd0);
      check("stall_count",     32'(b_count),     32'd2);
      tick();
    end
    b_stall = 0; b_in_valid = 0; #1;
    check("stall_rel0_data", b_out_data, 32'h11);
    check("stall_rel0_valid", 32'(b_out_valid), 32'd1);
    tick();
    check("stall_rel1_data", b_out_data, 32'h22);
    check("stall_rel1_valid", 32'(b_out_valid), 32'd1);
    tick();
    check("stall_drain_valid", 32'(b_out_valid), 32'd0);
    check("stall_drain_count", 32'(b_count), 32'd0);

    // Flush together with stall while full and an input is offered
    b_out_ready = 0;
    b_in_valid = 1;
    for (int i = 1; i <= 3; i++) begin
      b_in_data = 32'(i);
      tick();
    end
    check("flush_pre_count", 32'(b_count), 32'd3);
    b_flush = 1; b_stall = 1; b_in_data = 32'h99; #1;
    check("flush_in_ready",  32'(b_in_ready),  32'd0);
    check("flush_out_valid", 32'(b_out_valid), 32'd0);
    tick();
    b_flush = 0; b_stall = 0; b_in_valid = 0; b_out_ready = 1; #1;
    check("flush_post_count",    32'(b_count),     32'd0);
    check("flush_post_valid",    32'(b_out_valid), 32'd0);
    check("flush_post_in_ready", 32'(b_in_ready),  32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("flush_no_output", 32'(b_out_valid), 32'd0);
    end

    // DEPTH=1 full pass-through for 8 cycles
    c_out_ready = 0;
    c_in_valid = 1; c_in_data = 32'h100; tick();
    c_in_data = 32'h101; #1;
    check("d1_full_count",    32'(c_count),    32'd1);
    check("d1_full_in_ready", 32'(c_in_ready), 32'd0);
    c_out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      c_in_data = 32'h101 + 32'(i);
      #1;
      check("d1_out_valid", 32'(c_out_valid), 32'd1);
      check("d1_out_data",  c_out_data,       32'h100 + 32'(i));
      check("d1_in_ready",  32'(c_in_ready),  32'd1);
      check("d1_count",     32'(c_count),     32'd1);
      tick();
    end
    c_in_valid = 0; #1;
    check("d1_last_data", c_out_data, 32'h108);
    tick();
    check("d1_drained", 32'(c_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_buf.md
# pipeline_stage_buf

Parametrised elastic pipeline register chain between processor stages. It carries a DW-bit payload through DEPTH valid-tagged stages with a valid/ready handshake on both sides, a global stall, a global flush and bubble collapse. A blocked output no longer freezes the whole chain. It replaces fixed stall-only stage registers wherever a stage boundary needs back-pressure, squash on branch/trap, or more than one register of slack.

## Interface
Parameters:
- DW, 32, payload width in bits (≥1)
- DEPTH, 2, number of register stages (1..8)
- CNTW, $clog2(DEPTH+1), width of occupancy count

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_ni  input  1  reset; asynchronous assert, active-low
- in_valid_i  input  1  upstream presents a payload
- in_ready_o  output  1  chain accepts in_data_i this cycle
- in_data_i  input  DW  upstream payload
- stall_i  input  1  freeze all stages; no transfer on either side
- flush_i  input  1  squash every stage; no transfer on either side
- out_valid_o  output  1  stage DEPTH-1 holds a deliverable payload
- out_ready_i  input  1  downstream accepts out_data_o
- out_data_o  output  DW  payload of stage DEPTH-1
- count_o  output  CNTW  number of valid stages

## Operation
- State per stage k (0 = input side, DEPTH-1 = output side): valid bit v[k] and payload d[k].
- Advance enables, combinational, computed from the output side back to the input side:
  - en[DEPTH-1] = ~v[DEPTH-1] | out_ready_i
  - en[k] = ~v[k] | en[k+1]
  - This is bubble collapse: an empty stage always absorbs its predecessor, even when the output is blocked.
- Handshake outputs:
  - in_ready_o = en[0] & ~stall_i & ~flush_i
  - out_valid_o = v[DEPTH-1] & ~stall_i & ~flush_i
  - out_data_o = d[DEPTH-1], driven unconditionally.
- Transfers: input transfer = in_valid_i & in_ready_o; output transfer = out_valid_o & out_ready_i.
- Normal update (stall_i=0, flush_i=0), for each k with en[k]=1:
  - v[k] ← v[k-1] and d[k] ← d[k-1]; stage 0 takes in_valid_i and in_data_i.
  - d[k] loads only when the incoming valid is 1; otherwise it holds its old value. v[k] still updates.
- stall_i=1, flush_i=0: all v and d hold; in_ready_o=0; out_valid_o=0.
- flush_i=1 (priority over stall_i): all v ← 0 on the next edge; d holds; in_ready_o=0; out_valid_o=0. A payload offered in the flush cycle is dropped.
- count_o = popcount(v), from registers only. Range 0..DEPTH.
- Full: all v=1 and out_ready_i=0 → in_ready_o=0 and the chain holds.
- Full with out_ready_i=1: every stage advances, in_ready_o=1, and simultaneous in/out transfer keeps count_o constant.
- DEPTH=1 degenerates to a single skid-less register: in_ready_o = (~v[0] | out_ready_i) & ~stall_i & ~flush_i.
- Payload is never reordered, duplicated or lost except by flush_i or reset.

## Timing
- Reset (rst_ni=0, at any time, including mid-transfer): immediately all v=0 and all d=0. Consequently out_valid_o=0, out_data_o=0, count_o=0, and in_ready_o=1 unless stall_i or flush_i is asserted. In-flight payloads are discarded.
- Latency, empty chain: a payload accepted at edge t is presented on out_valid_o in the cycle after edge t+DEPTH-1, i.e. DEPTH cycles after the acceptance cycle.
- Throughput: 1 payload/cycle sustained while out_ready_i=1 and stall_i=0.
- Capacity: DEPTH payloads held while out_ready_i=0.
- in_ready_o depends combinationally on out_ready_i, stall_i and flush_i. out_valid_o and out_data_o depend on registers and stall_i/flush_i only, never on in_valid_i.
- Flush at edge t: count_o=0 from t onward. A new input can be accepted in the first cycle after flush_i drops.

## Test plan
- Reset/idle, DEPTH=2: rst_ni=0 mid-stream with 2 entries held → out_valid_o=0, out_data_o=0, count_o=0, in_ready_o=1 immediately, before any clock edge.
- Streaming, DEPTH=3, DW=32: push 0x1..0x10 on consecutive cycles with out_ready_i=1 → first out_valid_o 3 cycles after the first acceptance; all 16 payloads arrive in order, one per cycle.
- Back-pressure and bubble collapse, DEPTH=3: push A, then 2 idle cycles, then B and C with out_ready_i=0 → count_o reaches 3 and in_ready_o=0; releasing out_ready_i yields A, B, C in consecutive cycles.
- Stall: stall_i=1 for 4 cycles with 2 entries held and in_valid_i=1, out_ready_i=1 → no transfers, count_o stays 2, payloads unchanged after release.
- Flush vs stall: flush_i=1 and stall_i=1 together, with 3 entries held and in_valid_i=1 → next cycle count_o=0, out_valid_o=0, and the offered payload is not accepted.
- Full pass-through, DEPTH=1: register full, in_valid_i=1, out_ready_i=1 for 8 cycles → one output per cycle, count_o stays 1.
